select_ui_scroll: RTL and testbench

Parametrised successor of the menu-select UI page. It renders a scrollable window of VIS_ROWS menu items on the character LCD, with a '>' cursor in column 0. UP/DOWN keys move the cursor, ENTER requests a change to the selected item's UI id, and BACK requests a change to a fixed parent UI. It sits between the keypad decoder and the LCD character driver, under the UI manager that drives is_active and consumes change_req/next_ui_id.

---
 rtl/select_ui_scroll.sv | 218 +++++++++++++++++++++
 tb/tb_select_ui_scroll.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/select_ui_scroll.sv
// Scrollable menu-select UI page: draws a VIS_ROWS window of menu labels with a '>' cursor.
// Optional macro SELECT_UI_WRAP_EN makes UP/DOWN wrap around the ends of the menu.
module select_ui_scroll #(
    parameter int MENU_COUNT = 5,
    parameter int VIS_ROWS   = 2,
    parameter int STR_LEN    = 7,
    parameter logic [MENU_COUNT*STR_LEN*8-1:0] MENU_STR_FLAT  = {MENU_COUNT*STR_LEN{8'h20}},
    parameter logic [MENU_COUNT*4-1:0]         NEXT_UUID_FLAT = '0,
    parameter logic [3:0]                      BACK_UUID      = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       is_active,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic       lcd_req,
    output logic [1:0] lcd_row,
    output logic [3:0] lcd_col,
    output logic [7:0] lcd_char,
    output logic       change_req,
    output logic [3:0] next_ui_id
);
    typedef enum logic [2:0] {IDLE, DRAW_REQ, DRAW_WAIT, DRAW_GAP, READY} state_t;
    typedef enum logic [1:0] {K_UP, K_DOWN, K_ENTER, K_BACK} key_t;

    localparam logic [3:0] LAST_ITEM = 4'(MENU_COUNT - 1);
    localparam logic [1:0] LAST_ROW  = 2'(VIS_ROWS - 1);
    localparam logic [3:0] LAST_COL  = 4'(STR_LEN);
    localparam logic [4:0] VIS_W     = 5'(VIS_ROWS);
    localparam logic [3:0] VIS_M1    = 4'(VIS_ROWS - 1);
    localparam logic [3:0] WRAP_TOP  = (MENU_COUNT > VIS_ROWS) ? 4'(MENU_COUNT - VIS_ROWS) : 4'd0;

    state_t     state_r, next_state_s;
    logic [3:0] cursor_r, top_r, cursor_nxt_s, top_nxt_s;
    logic [1:0] row_r;
    logic [3:0] col_r;
    logic       key_valid_d_r, pend_valid_r, change_req_r;
    key_t       pend_key_r, key_code_s;
    logic [3:0] next_ui_id_r;
    logic       key_rise_s, key_known_s, consume_s, moved_s;
    logic [4:0] draw_item_s;
    logic [7:0] draw_char_s;
    logic       unused_busy_s;

    // Label character for column col (1..STR_LEN) of item; blank past the end of the menu
    function automatic logic [7:0] label_char(input logic [4:0] item, input logic [3:0] col);
        int idx;
        if (item >= 5'(MENU_COUNT) || col == 4'd0 || col > LAST_COL) begin
            label_char = 8'h20;
        end else begin
            idx = ((MENU_COUNT - 1 - int'(item)) * STR_LEN + (STR_LEN - int'(col))) * 8;
            label_char = MENU_STR_FLAT[idx +: 8];
        end
    endfunction

    assign unused_busy_s = lcd_busy;
    assign key_rise_s    = key_valid & ~key_valid_d_r;
    assign consume_s     = is_active && (state_r == READY) && pend_valid_r;

    // Key code decode
    always_comb begin
        key_known_s = 1'b1;
        key_code_s  = K_UP;
        case (key_data)
            8'h80:   key_code_s = K_UP;
            8'h81:   key_code_s = K_DOWN;
            8'h0D:   key_code_s = K_ENTER;
            8'h1B:   key_code_s = K_BACK;
            default: key_known_s = 1'b0;
        endcase
    end

    // Cursor/window update for the pending key
    always_comb begin
        cursor_nxt_s = cursor_r;
        top_nxt_s    = top_r;
        case (pend_key_r)
            K_UP: begin
                if (cursor_r != 4'd0) begin
                    cursor_nxt_s = cursor_r - 4'd1;
                    if (cursor_nxt_s < top_r) top_nxt_s = cursor_nxt_s;
                    else                      top_nxt_s = top_r;
                end else begin
`ifdef SELECT_UI_WRAP_EN
                    cursor_nxt_s = LAST_ITEM;
                    top_nxt_s    = WRAP_TOP;
`else
                    cursor_nxt_s = cursor_r;
                    top_nxt_s    = top_r;
`endif
                end
            end
            K_DOWN: begin
                if (cursor_r != LAST_ITEM) begin
                    cursor_nxt_s = cursor_r + 4'd1;
                    if ({1'b0, cursor_nxt_s} >= {1'b0, top_r} + VIS_W) top_nxt_s = cursor_nxt_s - VIS_M1;
                    else                                               top_nxt_s = top_r;
                end else begin
`ifdef SELECT_UI_WRAP_EN
                    cursor_nxt_s = 4'd0;
                    top_nxt_s    = 4'd0;
`else
                    cursor_nxt_s = cursor_r;
                    top_nxt_s    = top_r;
`endif
                end
            end
            default: begin
                cursor_nxt_s = cursor_r;
                top_nxt_s    = top_r;
            end
        endcase
    end

    assign moved_s = (cursor_nxt_s != cursor_r);

    // Next-state logic; losing is_active overrides everything
    always_comb begin
        next_state_s = state_r;
        if (!is_active) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:      next_state_s = DRAW_REQ;
                DRAW_REQ:  next_state_s = DRAW_WAIT;
                DRAW_WAIT: next_state_s = lcd_done ? DRAW_GAP : DRAW_WAIT;
                DRAW_GAP:  next_state_s = (row_r == LAST_ROW && col_r == LAST_COL) ? READY : DRAW_REQ;
                READY:     next_state_s = (consume_s && moved_s) ? DRAW_REQ : READY;
                default:   next_state_s = IDLE;
            endcase
        end
    end

    // State, key capture, cursor/window and draw-position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cursor_r      <= 4'd0;
            top_r         <= 4'd0;
            row_r         <= 2'd0;
            col_r         <= 4'd0;
            key_valid_d_r <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_key_r    <= K_UP;
            change_req_r  <= 1'b0;
            next_ui_id_r  <= 4'd0;
        end else begin
            state_r       <= next_state_s;
            key_valid_d_r <= key_valid;
            change_req_r  <= 1'b0;
            if (!is_active) begin
                pend_valid_r <= 1'b0;
            end else if (key_rise_s && key_known_s && (!pend_valid_r || consume_s)) begin
                pend_valid_r <= 1'b1;
                pend_key_r   <= key_code_s;
            end else if (consume_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
            case (state_r)
                IDLE: begin
                    if (is_active) begin
                        cursor_r <= 4'd0;
                        top_r    <= 4'd0;
                        row_r    <= 2'd0;
                        col_r    <= 4'd0;
                    end
                end
                DRAW_GAP: begin
                    if (col_r != LAST_COL) begin
                        col_r <= col_r + 4'd1;
                    end else begin
                        col_r <= 4'd0;
                        row_r <= (row_r == LAST_ROW) ? 2'd0 : row_r + 2'd1;
                    end
                end
                READY: begin
                    if (consume_s) begin
                        cursor_r <= cursor_nxt_s;
                        top_r    <= top_nxt_s;
                        case (pend_key_r)
                            K_ENTER: begin
                                next_ui_id_r <= NEXT_UUID_FLAT[{cursor_r, 2'b00} +: 4];
                                change_req_r <= 1'b1;
                            end
                            K_BACK: begin
                                next_ui_id_r <= BACK_UUID;
                                change_req_r <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign draw_item_s = {3'd0, row_r} + {1'b0, top_r};

    // Character for the current draw position
    always_comb begin
        draw_char_s = 8'h20;
        if (col_r == 4'd0) draw_char_s = (draw_item_s == {1'b0, cursor_r}) ? 8'h3E : 8'h20;
        else               draw_char_s = label_char(draw_item_s, col_r);
    end

    // lcd_req is decoded from the state register and gated so deactivation drops it at once
    assign lcd_req    = is_active && (state_r == DRAW_REQ || state_r == DRAW_WAIT);
    assign lcd_row    = row_r;
    assign lcd_col    = col_r;
    assign lcd_char   = lcd_req ? draw_char_s : 8'h00;
    assign change_req = change_req_r;
    assign next_ui_id = next_ui_id_r;
endmodule

// File: tb/tb_select_ui_scroll.sv
// Bench for select_ui_scroll: LCD responder, screen model and a cursor/window reference model.
// Honours SELECT_UI_WRAP_EN in the reference model.
module tb_select_ui_scroll;
    logic       clk = 1'b0;
    logic       rst, is_active, key_valid;
    logic       lcd_busy = 1'b0;
    logic       lcd_done = 1'b0;
    logic [7:0] key_data;
    logic       lcd_req, change_req;
    logic [1:0] lcd_row;
    logic [3:0] lcd_col, next_ui_id;
    logic [7:0] lcd_char;

    select_ui_scroll #(
        .MENU_COUNT(5), .VIS_ROWS(2), .STR_LEN(7),
        .MENU_STR_FLAT({"SETTING", "ENCODE ", "DECODE ", "MORSE  ", "ABOUT  "}),
        .NEXT_UUID_FLAT({4'd9, 4'd8, 4'd3, 4'd2, 4'd4}),
        .BACK_UUID(4'd1)
    ) dut (
        .clk(clk), .rst(rst), .is_active(is_active), .key_data(key_data), .key_valid(key_valid),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done), .lcd_req(lcd_req), .lcd_row(lcd_row),
        .lcd_col(lcd_col), .lcd_char(lcd_char), .change_req(change_req), .next_ui_id(next_ui_id)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int writes = 0, chg_cnt = 0, overlap = 0, wait_cnt = 0;
    logic [3:0]  chg_id = 4'd0;
    logic [7:0]  scr [2][8];
    logic [55:0] label [5] = '{"SETTING", "ENCODE ", "DECODE ", "MORSE  ", "ABOUT  "};
    int          uuid [5]  = '{4, 2, 3, 8, 9};
    int          mcur = 0, mtop = 0;

    // LCD driver model: done pulse five cycles after a request, recording the written char
    always @(negedge clk) begin
        if (rst) begin
            lcd_done = 1'b0;
            wait_cnt = 0;
        end else if (lcd_done) begin
            lcd_done = 1'b0;
        end else if (lcd_req) begin
            if (wait_cnt == 4) begin
                lcd_done = 1'b1;
                scr[lcd_row[0]][lcd_col[2:0]] = lcd_char;
                writes++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        lcd_busy = lcd_req && !lcd_done;
    end

    // UI-change monitor
    always @(negedge clk) begin
        if (change_req) begin
            chg_cnt++;
            chg_id = next_ui_id;
            if (lcd_req) overlap++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_screen(input string tag);
        logic [63:0] got, exp;
        int item;
        for (int r = 0; r < 2; r++) begin
            item = mtop + r;
            for (int c = 0; c < 8; c++) got[(7 - c) * 8 +: 8] = scr[r][c];
            exp[63:56] = (item == mcur) ? 8'h3E : 8'h20;
            exp[55:0]  = (item < 5) ? label[item] : {7{8'h20}};
            chk(tag, got, exp);
        end
    endtask

    task automatic settle(input int quiet);
        int q = 0, n = 0;
        while (q < quiet && n < 2000) begin
            @(negedge clk); #1;
            n++;
            if (lcd_req) q = 0;
            else         q++;
        end
        chk("settle_timeout", 64'(n < 2000), 64'd1);
    endtask

    task automatic press(input logic [7:0] code);
        @(negedge clk);
        key_data  = code;
        key_valid = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        key_valid = 1'b0;
        key_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
    endtask

    task automatic activate();
        int w0;
        is_active = 1'b0;
        repeat (3) @(negedge clk);
        w0 = writes;
        is_active = 1'b1;
        mcur = 0;
        mtop = 0;
        settle(50);
        chk("activate_writes", 64'(writes - w0), 64'd16);
        chk_screen("activate_screen");
    endtask

    // Reference model of one key: returns expected redraw and expected UI change
    task automatic model_key(input logic [7:0] code, output bit redraw, output bit chg, output int id);
        int old = mcur;
        bit wrap = 1'b0;
`ifdef SELECT_UI_WRAP_EN
        wrap = 1'b1;
`endif
        chg = 1'b0;
        id  = 0;
        case (code)
            8'h80: begin
                if (mcur > 0) mcur--;
                else if (wrap) begin mcur = 4; mtop = 3; end
                if (mcur < mtop) mtop = mcur;
            end
            8'h81: begin
                if (mcur < 4) mcur++;
                else if (wrap) begin mcur = 0; mtop = 0; end
                if (mcur >= mtop + 2) mtop = mcur - 1;
            end
            8'h0D: begin chg = 1'b1; id = uuid[mcur]; end
            8'h1B: begin chg = 1'b1; id = 1; end
            default: ;
        endcase
        redraw = (mcur != old);
    endtask

    task automatic do_key(input logic [7:0] code);
        int  w0 = writes, c0 = chg_cnt, id;
        bit  redraw, chg;
        model_key(code, redraw, chg, id);
        press(code);
        settle(50);
        chk("key_writes", 64'(writes - w0), redraw ? 64'd16 : 64'd0);
        chk("key_change_cnt", 64'(chg_cnt - c0), chg ? 64'd1 : 64'd0);
        if (chg) chk("key_ui_id", 64'(chg_id), 64'(id));
        chk_screen("key_screen");
    endtask

    initial begin
        int w0, c0, n;
        bit redraw, chg;
        int id;
        logic [7:0] codes [5];
        codes[0] = 8'h80; codes[1] = 8'h81; codes[2] = 8'h0D; codes[3] = 8'h1B; codes[4] = 8'h41;
        rst = 1'b1; is_active = 1'b0; key_valid = 1'b0; key_data = 8'h00;
        repeat (3) @(negedge clk); #1;
        chk("reset_outputs", {41'd0, lcd_req, change_req, next_ui_id, lcd_row, lcd_col, lcd_char}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk); #1;
        chk("idle_outputs", {41'd0, lcd_req, change_req, next_ui_id, lcd_row, lcd_col, lcd_char}, 64'd0);

        activate();
        do_key(8'h80);

        activate();
        do_key(8'h81);
        do_key(8'h0D);
        chk("down_enter_id", 64'(chg_id), 64'd2);

        activate();
        repeat (3) do_key(8'h81);
        do_key(8'h0D);
        chk("down3_enter_id", 64'(chg_id), 64'd8);

        // Two DOWNs during the initial draw: only the first survives
        is_active = 1'b0;
        repeat (3) @(negedge clk);
        w0 = writes;
        is_active = 1'b1;
        mcur = 0; mtop = 0;
        repeat (20) @(negedge clk);
        press(8'h81);
        repeat (10) @(negedge clk);
        press(8'h81);
        settle(50);
        model_key(8'h81, redraw, chg, id);
        chk("middraw_writes", 64'(writes - w0), 64'd32);
        chk_screen("middraw_screen");
        do_key(8'h1B);
        chk("back_id", 64'(chg_id), 64'd1);

        // Deactivation during the fifth character write
        is_active = 1'b0;
        repeat (3) @(negedge clk);
        w0 = writes;
        c0 = chg_cnt;
        is_active = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(writes - w0 == 4 && lcd_req) && n < 500);
        chk("fifth_write_reached", 64'(n < 500), 64'd1);
        is_active = 1'b0;
        #1;
        chk("deact_req_drop", 64'(lcd_req), 64'd0);
        repeat (10) @(negedge clk); #1;
        chk("deact_quiet", {62'd0, lcd_req, change_req}, 64'd0);
        chk("deact_no_change", 64'(chg_cnt - c0), 64'd0);
        w0 = writes;
        is_active = 1'b1;
        mcur = 0; mtop = 0;
        settle(50);
        chk("reactivate_writes", 64'(writes - w0), 64'd16);
        chk_screen("reactivate_screen");

        activate();
        repeat (40) do_key(codes[$urandom_range(0, 4)]);

        // Asynchronous reset in the middle of a draw
        is_active = 1'b0;
        repeat (3) @(negedge clk);
        is_active = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!lcd_req && n < 50);
        chk("draw_started", 64'(lcd_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", 64'(lcd_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        chk("req_change_overlap", 64'(overlap), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
